// File: rtl/noc_mem_requester.sv
// noc0 memory requester: turns one client load/store into a LOAD_MEM/STORE_MEM message and returns the ack's data or completion.
// Latency: header leaves 1 cycle after accept; data and ack flits are combinational pass-through; done 1 cycle after the final ack flit.
// Backpressure: single outstanding request; a stalled header is held in a register; data flits follow val/rdy end to end.
module noc_mem_requester #(
    parameter int SRC_X    = 0,
    parameter int SRC_Y    = 0,
    parameter int DST_X    = 0,
    parameter int DST_Y    = 0,
    parameter int DST_CHIP = 0,
    localparam int NOC_DATA_WIDTH      = 512,
    localparam int NOC_DATA_BYTES      = NOC_DATA_WIDTH / 8,
    localparam int BYTES_W             = $clog2(NOC_DATA_BYTES),
    localparam int MSG_ADDR_WIDTH      = 48,
    localparam int MSG_DATA_SIZE_WIDTH = 16,
    localparam int MSG_LENGTH_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req_val,
    input  logic                           i_req_write,
    input  logic [MSG_ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] i_req_size,
    output logic                           o_req_rdy,
    input  logic                           i_wr_data_val,
    input  logic [NOC_DATA_WIDTH-1:0]      i_wr_data,
    output logic                           o_wr_data_rdy,
    output logic                           o_rd_data_val,
    output logic [NOC_DATA_WIDTH-1:0]      o_rd_data,
    output logic                           o_rd_data_last,
    input  logic                           i_rd_data_rdy,
    output logic                           o_done,
    output logic                           o_resp_err,
    output logic                           o_noc0_vrtoc_val,
    output logic [NOC_DATA_WIDTH-1:0]      o_noc0_vrtoc_data,
    input  logic                           i_noc0_vrtoc_rdy,
    input  logic                           i_noc0_ctovr_val,
    input  logic [NOC_DATA_WIDTH-1:0]      i_noc0_ctovr_data,
    output logic                           o_noc0_ctovr_rdy
);

    localparam logic [7:0] MSG_TYPE_LOAD_MEM      = 8'd19;
    localparam logic [7:0] MSG_TYPE_STORE_MEM     = 8'd20;
    localparam logic [7:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd24;
    localparam logic [7:0] MSG_TYPE_STORE_MEM_ACK = 8'd25;

    // Single-flit header, routing fields at the MSB end, zero padding at the LSB end.
    localparam int HDR_USED_W = 14 + 8 + 8 + 4 + MSG_LENGTH_WIDTH + 8 + MSG_ADDR_WIDTH
                              + MSG_DATA_SIZE_WIDTH + 14 + 8 + 8 + 4;

    typedef struct packed {
        logic [13:0]                      dst_chip_id;
        logic [7:0]                       dst_x_coord;
        logic [7:0]                       dst_y_coord;
        logic [3:0]                       fbits;
        logic [MSG_LENGTH_WIDTH-1:0]      msg_len;
        logic [7:0]                       msg_type;
        logic [MSG_ADDR_WIDTH-1:0]        addr;
        logic [MSG_DATA_SIZE_WIDTH-1:0]   data_size;
        logic [13:0]                      src_chip_id;
        logic [7:0]                       src_x_coord;
        logic [7:0]                       src_y_coord;
        logic [3:0]                       src_fbits;
        logic [NOC_DATA_WIDTH-HDR_USED_W-1:0] rsvd;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_DATA,
        ST_WAIT_HDR,
        ST_RECV_DATA,
        ST_DONE
    } state_t;

    state_t                      r_state;
    hdr_t                        r_hdr;
    logic                        r_is_write;
    logic                        r_req_rdy;
    logic                        r_resp_err;
    logic [MSG_LENGTH_WIDTH-1:0] r_cnt;
    logic [MSG_LENGTH_WIDTH-1:0] r_resp_len;

    logic [MSG_LENGTH_WIDTH-1:0] w_flits;
    hdr_t                        w_new_hdr;
    hdr_t                        w_in_hdr;
    logic                        w_data_last;
    logic                        w_resp_last;
    logic                        w_unused_in_hdr;

    // Flit count rounds the byte count up to whole flits.
    assign w_flits = MSG_LENGTH_WIDTH'(i_req_size >> BYTES_W)
                   + MSG_LENGTH_WIDTH'(|i_req_size[BYTES_W-1:0]);

    assign w_in_hdr        = hdr_t'(i_noc0_ctovr_data);
    // Only msg_type/msg_len of the ack header are consumed; the rest is folded here.
    assign w_unused_in_hdr = ^w_in_hdr;

    assign w_data_last = (r_cnt == r_hdr.msg_len - MSG_LENGTH_WIDTH'(1));
    assign w_resp_last = (r_cnt == r_resp_len - MSG_LENGTH_WIDTH'(1));

    // Build the outbound header from the request fields and fixed coordinates.
    always_comb begin
        w_new_hdr             = '0;
        w_new_hdr.dst_chip_id = 14'(DST_CHIP);
        w_new_hdr.dst_x_coord = 8'(DST_X);
        w_new_hdr.dst_y_coord = 8'(DST_Y);
        w_new_hdr.msg_len     = i_req_write ? w_flits : '0;
        w_new_hdr.msg_type    = i_req_write ? MSG_TYPE_STORE_MEM : MSG_TYPE_LOAD_MEM;
        w_new_hdr.addr        = i_req_addr;
        w_new_hdr.data_size   = i_req_size;
        w_new_hdr.src_x_coord = 8'(SRC_X);
        w_new_hdr.src_y_coord = 8'(SRC_Y);
    end

    // Transaction FSM: accept, send header, stream store data, take ack, stream load data, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hdr      <= '0;
            r_is_write <= 1'b0;
            r_req_rdy  <= 1'b0;
            r_resp_err <= 1'b0;
            r_cnt      <= '0;
            r_resp_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_val && r_req_rdy) begin
                        r_hdr      <= w_new_hdr;
                        r_is_write <= i_req_write;
                        r_resp_err <= 1'b0;
                        r_req_rdy  <= 1'b0;
                        r_state    <= ST_SEND_HDR;
                    end else begin
                        r_req_rdy  <= 1'b1;
                    end
                end
                ST_SEND_HDR: begin
                    if (i_noc0_vrtoc_rdy) begin
                        r_cnt <= '0;
                        if (r_is_write && (r_hdr.msg_len != '0)) begin
                            r_state <= ST_SEND_DATA;
                        end else begin
                            r_state <= ST_WAIT_HDR;
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (i_wr_data_val && i_noc0_vrtoc_rdy) begin
                        if (w_data_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_WAIT_HDR;
                        end else begin
                            r_cnt   <= r_cnt + MSG_LENGTH_WIDTH'(1);
                        end
                    end
                end
                ST_WAIT_HDR: begin
                    if (i_noc0_ctovr_val) begin
                        r_resp_len <= w_in_hdr.msg_len;
                        r_cnt      <= '0;
                        if (w_in_hdr.msg_type != (r_is_write ? MSG_TYPE_STORE_MEM_ACK
                                                             : MSG_TYPE_LOAD_MEM_ACK)) begin
                            r_resp_err <= 1'b1;
                        end
                        if (r_is_write || (w_in_hdr.msg_len == '0)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RECV_DATA;
                        end
                    end
                end
                ST_RECV_DATA: begin
                    if (i_noc0_ctovr_val && i_rd_data_rdy) begin
                        if (w_resp_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + MSG_LENGTH_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_req_rdy <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-state steering of the noc0 and client handshakes; data phases are pure pass-through.
    always_comb begin
        o_noc0_vrtoc_val  = 1'b0;
        o_noc0_vrtoc_data = '0;
        o_wr_data_rdy     = 1'b0;
        o_noc0_ctovr_rdy  = 1'b0;
        o_rd_data_val     = 1'b0;
        o_rd_data         = '0;
        o_rd_data_last    = 1'b0;
        case (r_state)
            ST_SEND_HDR: begin
                o_noc0_vrtoc_val  = 1'b1;
                o_noc0_vrtoc_data = r_hdr;
            end
            ST_SEND_DATA: begin
                o_noc0_vrtoc_val  = i_wr_data_val;
                o_noc0_vrtoc_data = i_wr_data;
                o_wr_data_rdy     = i_noc0_vrtoc_rdy;
            end
            ST_WAIT_HDR: begin
                o_noc0_ctovr_rdy  = 1'b1;
            end
            ST_RECV_DATA: begin
                o_noc0_ctovr_rdy  = i_rd_data_rdy;
                o_rd_data_val     = i_noc0_ctovr_val;
                o_rd_data         = i_noc0_ctovr_data;
                o_rd_data_last    = w_resp_last;
            end
            default: begin
            end
        endcase
    end

    assign o_req_rdy  = r_req_rdy;
    assign o_done     = (r_state == ST_DONE);
    assign o_resp_err = r_resp_err;

endmodule

// File: tb/tb_noc_mem_requester.sv
// Directed bench for noc_mem_requester with outbound/load-data scoreboards.
// Header layout and message codes are modelled independently here.
module tb_noc_mem_requester;

    localparam int DW = 512;
    localparam logic [7:0] T_LOAD      = 8'd19;
    localparam logic [7:0] T_STORE     = 8'd20;
    localparam logic [7:0] T_LOAD_ACK  = 8'd24;
    localparam logic [7:0] T_STORE_ACK = 8'd25;

    typedef struct packed {
        logic [13:0]  dst_chip;
        logic [7:0]   dst_x;
        logic [7:0]   dst_y;
        logic [3:0]   fbits;
        logic [7:0]   msg_len;
        logic [7:0]   msg_type;
        logic [47:0]  addr;
        logic [15:0]  data_size;
        logic [13:0]  src_chip;
        logic [7:0]   src_x;
        logic [7:0]   src_y;
        logic [3:0]   src_fbits;
        logic [363:0] rsvd;
    } tb_hdr_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_val = 1'b0, req_write = 1'b0;
    logic [47:0]   req_addr = '0;
    logic [15:0]   req_size = '0;
    logic          req_rdy;
    logic          wr_data_val = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_data_rdy;
    logic          rd_data_val, rd_data_last;
    logic [DW-1:0] rd_data;
    logic          rd_data_rdy = 1'b1;
    logic          done, resp_err;
    logic          vrtoc_val;
    logic [DW-1:0] vrtoc_data;
    logic          vrtoc_rdy = 1'b1;
    logic          ctovr_val = 1'b0;
    logic [DW-1:0] ctovr_data = '0;
    logic          ctovr_rdy;

    int checks = 0;
    int failures = 0;
    int n_wr_xfer = 0, n_wr_rdy = 0, n_rd_val = 0;
    int n0;
    logic stall_mode = 1'b0;
    logic hs_req, hs_wr, hs_in;
    logic prev_out_stall = 1'b0;
    logic [DW-1:0] prev_out_data = '0;

    logic [DW-1:0] exp_out[$];
    rd_exp_t       exp_rd[$];

    noc_mem_requester #(
        .SRC_X(3), .SRC_Y(5), .DST_X(7), .DST_Y(1), .DST_CHIP(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_val(req_val), .i_req_write(req_write), .i_req_addr(req_addr),
        .i_req_size(req_size), .o_req_rdy(req_rdy),
        .i_wr_data_val(wr_data_val), .i_wr_data(wr_data), .o_wr_data_rdy(wr_data_rdy),
        .o_rd_data_val(rd_data_val), .o_rd_data(rd_data), .o_rd_data_last(rd_data_last),
        .i_rd_data_rdy(rd_data_rdy), .o_done(done), .o_resp_err(resp_err),
        .o_noc0_vrtoc_val(vrtoc_val), .o_noc0_vrtoc_data(vrtoc_data),
        .i_noc0_vrtoc_rdy(vrtoc_rdy), .i_noc0_ctovr_val(ctovr_val),
        .i_noc0_ctovr_data(ctovr_data), .o_noc0_ctovr_rdy(ctovr_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_hdr(input logic wr, input logic [47:0] a, input logic [15:0] sz);
        tb_hdr_t h;
        h           = '0;
        h.dst_chip  = 14'd2;
        h.dst_x     = 8'd7;
        h.dst_y     = 8'd1;
        h.msg_len   = wr ? 8'((int'(sz) + 63) / 64) : 8'd0;
        h.msg_type  = wr ? T_STORE : T_LOAD;
        h.addr      = a;
        h.data_size = sz;
        h.src_x     = 8'd3;
        h.src_y     = 8'd5;
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int seed, input int i);
        logic [DW-1:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hA500_0000 ^ (seed << 16) ^ (i << 8) ^ k;
        return d;
    endfunction

    // One clock: sample handshakes before the edge, return just after it.
    task automatic cyc();
        @(negedge clk);
        hs_req = req_val && req_rdy;
        hs_wr  = wr_data_val && wr_data_rdy;
        hs_in  = ctovr_val && ctovr_rdy;
        @(posedge clk);
        #1;
        if (stall_mode) begin
            vrtoc_rdy   = ($urandom_range(0, 3) != 0);
            rd_data_rdy = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send_req(input logic wr, input logic [47:0] a, input logic [15:0] sz);
        logic ok;
        ok = 1'b0;
        exp_out.push_back(mk_hdr(wr, a, sz));
        req_val = 1'b1; req_write = wr; req_addr = a; req_size = sz;
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (hs_req) begin ok = 1'b1; break; end
        end
        req_val = 1'b0;
        check("req_accepted", ok, 1'b1);
    endtask

    task automatic wait_out_empty(input string tag);
        for (int n = 0; n < 100 && exp_out.size() != 0; n++) cyc();
        check(tag, exp_out.size(), 0);
    endtask

    task automatic send_wr(input int nflits, input int seed);
        logic ok;
        for (int i = 0; i < nflits; i++) begin
            ok = 1'b0;
            exp_out.push_back(mk_data(seed, i));
            if (stall_mode) repeat ($urandom_range(0, 2)) cyc();
            wr_data = mk_data(seed, i);
            wr_data_val = 1'b1;
            for (int n = 0; n < 100; n++) begin
                cyc();
                if (hs_wr) begin ok = 1'b1; break; end
            end
            wr_data_val = 1'b0;
            check("wr_flit_taken", ok, 1'b1);
        end
    endtask

    task automatic send_in(input string tag, input logic [DW-1:0] d);
        logic ok;
        ok = 1'b0;
        ctovr_data = d;
        ctovr_val = 1'b1;
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (hs_in) begin ok = 1'b1; break; end
        end
        ctovr_val = 1'b0;
        check(tag, ok, 1'b1);
    endtask

    task automatic send_ack(input logic [7:0] t, input logic [7:0] len);
        tb_hdr_t h;
        h = '0;
        h.msg_type = t; h.msg_len = len;
        h.dst_x = 8'd3; h.dst_y = 8'd5; h.src_x = 8'd7; h.src_y = 8'd1;
        send_in("ack_taken", h);
    endtask

    task automatic send_rd(input int nflits, input int seed);
        rd_exp_t e;
        for (int i = 0; i < nflits; i++) begin
            e.d = mk_data(seed, i);
            e.last = (i == nflits - 1);
            exp_rd.push_back(e);
            if (stall_mode) repeat ($urandom_range(0, 2)) cyc();
            send_in("rd_flit_taken", e.d);
        end
    endtask

    // Scoreboard: pop expected flits as the DUT transfers them; outbound stalls must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_out_stall) begin
                check("out_hold_val", vrtoc_val, 1'b1);
                check("out_hold_dat", vrtoc_data, prev_out_data);
            end
            if (vrtoc_val && vrtoc_rdy) begin
                checks++;
                assert (exp_out.size() != 0) else begin
                    failures++;
                    $error("FAIL out_extra observed=%0h expected=none", vrtoc_data);
                end
                if (exp_out.size() != 0) check("out_flit", vrtoc_data, exp_out.pop_front());
            end
            if (rd_data_val && rd_data_rdy) begin
                checks++;
                assert (exp_rd.size() != 0) else begin
                    failures++;
                    $error("FAIL rd_extra observed=%0h expected=none", rd_data);
                end
                if (exp_rd.size() != 0) begin
                    check("rd_last", rd_data_last, exp_rd[0].last);
                    check("rd_flit", rd_data, exp_rd.pop_front().d);
                end
            end
            if (wr_data_val && wr_data_rdy) n_wr_xfer++;
            if (wr_data_rdy) n_wr_rdy++;
            if (rd_data_val) n_rd_val++;
            prev_out_stall = vrtoc_val && !vrtoc_rdy;
            prev_out_data  = vrtoc_data;
        end else begin
            prev_out_stall = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_req_rdy", req_rdy, 1'b0);
        check("rst_out_val", vrtoc_val, 1'b0);
        check("rst_ctovr_rdy", ctovr_rdy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", resp_err, 1'b0);
        rst = 1'b0;
        cyc();
        check("post_rst_req_rdy", req_rdy, 1'b1);

        // Load 0x1000, 128 bytes, 2 data flits back
        send_req(1'b0, 48'h1000, 16'd128);
        wait_out_empty("load_hdr_sent");
        check("wait_ctovr_rdy", ctovr_rdy, 1'b1);
        send_ack(T_LOAD_ACK, 8'd2);
        send_rd(2, 1);
        check("load_done", done, 1'b1);
        check("load_err", resp_err, 1'b0);
        check("done_req_rdy", req_rdy, 1'b0);
        cyc();
        check("load_done_pulse", done, 1'b0);
        check("idle_req_rdy", req_rdy, 1'b1);
        check("load_rd_drained", exp_rd.size(), 0);

        // Store 0x1005, 70 bytes -> 2 data flits
        n0 = n_wr_xfer;
        send_req(1'b1, 48'h1005, 16'd70);
        send_wr(2, 2);
        wait_out_empty("store_flits_sent");
        check("store_wr_count", n_wr_xfer - n0, 2);
        check("store_wait_ack", ctovr_rdy, 1'b1);
        send_ack(T_STORE_ACK, 8'd0);
        check("store_done", done, 1'b1);
        check("store_err", resp_err, 1'b0);
        cyc();

        // Zero-size store: header only, no data handshake
        n0 = n_wr_rdy;
        send_req(1'b1, 48'h2000, 16'd0);
        wait_out_empty("st0_hdr_sent");
        cyc();
        check("st0_wait_ack", ctovr_rdy, 1'b1);
        check("st0_no_wr_rdy", n_wr_rdy - n0, 0);
        send_ack(T_STORE_ACK, 8'd0);
        check("st0_done", done, 1'b1);
        cyc();

        // Zero-size load: ack with no data
        n0 = n_rd_val;
        send_req(1'b0, 48'h3000, 16'd0);
        wait_out_empty("ld0_hdr_sent");
        send_ack(T_LOAD_ACK, 8'd0);
        check("ld0_done", done, 1'b1);
        cyc();
        check("ld0_no_rd_val", n_rd_val - n0, 0);

        // Random stalls on a 4-flit store and a 4-flit load
        stall_mode = 1'b1;
        send_req(1'b1, 48'h4000, 16'd256);
        send_wr(4, 4);
        wait_out_empty("stall_st_sent");
        send_ack(T_STORE_ACK, 8'd0);
        check("stall_st_done", done, 1'b1);
        cyc();
        send_req(1'b0, 48'h5000, 16'd256);
        wait_out_empty("stall_ld_hdr_sent");
        send_ack(T_LOAD_ACK, 8'd4);
        send_rd(4, 5);
        check("stall_ld_done", done, 1'b1);
        stall_mode = 1'b0;
        vrtoc_rdy = 1'b1;
        rd_data_rdy = 1'b1;
        cyc();
        check("stall_rd_drained", exp_rd.size(), 0);

        // Wrong ack type on a load: sticky error, cleared by the next accept
        send_req(1'b0, 48'h6000, 16'd64);
        wait_out_empty("err_hdr_sent");
        send_ack(T_STORE_ACK, 8'd0);
        check("err_done", done, 1'b1);
        check("err_set", resp_err, 1'b1);
        cyc();
        check("err_sticky", resp_err, 1'b1);
        send_req(1'b0, 48'h7000, 16'd0);
        check("err_cleared", resp_err, 1'b0);
        wait_out_empty("err2_hdr_sent");
        send_ack(T_LOAD_ACK, 8'd0);
        check("err2_done", done, 1'b1);
        check("err2_clean", resp_err, 1'b0);
        cyc();

        // Reset in the middle of a 3-flit store
        send_req(1'b1, 48'h8000, 16'd192);
        send_wr(1, 8);
        rst = 1'b1;
        cyc();
        check("mid_rst_req_rdy", req_rdy, 1'b0);
        check("mid_rst_out_val", vrtoc_val, 1'b0);
        check("mid_rst_out_dat", vrtoc_data, '0);
        check("mid_rst_wr_rdy", wr_data_rdy, 1'b0);
        check("mid_rst_ctovr_rdy", ctovr_rdy, 1'b0);
        check("mid_rst_rd_val", rd_data_val, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", resp_err, 1'b0);
        rst = 1'b0;
        cyc();
        check("mid_rst_req_rdy_after", req_rdy, 1'b1);

        // Recovery after reset
        send_req(1'b0, 48'h9000, 16'd0);
        wait_out_empty("recov_hdr_sent");
        send_ack(T_LOAD_ACK, 8'd0);
        check("recov_done", done, 1'b1);
        cyc();

        check("final_out_drained", exp_out.size(), 0);
        check("final_rd_drained", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
